led_pwm_ctrl: RTL and testbench

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_pwm_pkg.sv | 26 ++
 rtl/led_pwm_channel.sv | 82 ++++++++
 rtl/led_pwm_ctrl.sv | 169 ++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: channel mode encodings,
// register word offsets and CTRL field positions.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_STATUS  = 4'h1;
    localparam logic [3:0] ADDR_CH_BASE = 4'h2;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_PRESC_LSB = 16;

    // Word address of the configuration register for channel idx.
    function automatic logic [3:0] ch_addr(input int idx);
        logic [3:0] off;
        off = 4'(idx);
        return ADDR_CH_BASE + off;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active configuration, blink toggle flag and the
// duty compare that produces the next LED value for this channel.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_wrap,
    input  logic             i_cfg_we,
    input  logic [CNT_W+1:0] i_cfg_wdata,
    input  logic [CNT_W-1:0] i_period,
    output logic [CNT_W+1:0] o_cfg,
    output logic             o_led_next
);

    logic [CNT_W+1:0] shadow_q;
    logic [CNT_W+1:0] shadow_d;
    logic [CNT_W+1:0] active_q;
    logic [CNT_W+1:0] active_d;
    logic             blink_q;
    logic             blink_d;
    mode_e            active_mode_s;
    logic [CNT_W-1:0] active_duty_s;

    assign active_mode_s = mode_e'(active_q[CNT_W+1:CNT_W]);
    assign active_duty_s = active_q[CNT_W-1:0];
    assign o_cfg         = shadow_q;

    // Next state of shadow/active configuration and the blink flag.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        blink_d  = blink_q;
        if (i_cfg_we) begin
            shadow_d = i_cfg_wdata;
        end else begin
            shadow_d = shadow_q;
        end
        // Active settings only change at a period boundary so a running pulse is never cut short.
        if (!i_en || i_wrap) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
        if (!i_en || (active_mode_s != MODE_BLINK)) begin
            blink_d = 1'b0;
        end else if (i_wrap) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    // LED value selected by the active mode.
    always_comb begin
        o_led_next = 1'b0;
        case (active_mode_s)
            MODE_OFF:   o_led_next = 1'b0;
            MODE_ON:    o_led_next = 1'b1;
            MODE_PWM:   o_led_next = (i_period < active_duty_s);
            MODE_BLINK: o_led_next = blink_q;
            default:    o_led_next = 1'b0;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shadow_q <= '0;
            active_q <= '0;
            blink_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            blink_q  <= blink_d;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller top: register file, prescaler, shared period counter and
// the per-channel instances; all outputs are registered.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int PRESC_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr,
    input  logic                i_rd,
    input  logic [3:0]          i_addr,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_ack,
    output logic [CHANNELS-1:0] o_led
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                en_q;
    logic                en_d;
    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_d;
    logic [PRESC_W-1:0]  presc_cnt_q;
    logic [PRESC_W-1:0]  presc_cnt_d;
    logic [CNT_W-1:0]    period_q;
    logic [CNT_W-1:0]    period_d;
    logic [CHANNELS-1:0] led_q;
    logic [CHANNELS-1:0] led_d;
    logic                ack_q;
    logic                ack_d;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;

    logic                ctrl_we_s;
    logic                tick_s;
    logic                wrap_s;
    logic [CHANNELS-1:0] cfg_we_s;
    logic [CHANNELS-1:0] led_next_s;
    logic [CNT_W+1:0]    ch_cfg_s [CHANNELS];
    logic [31:0]         rd_mux_s;
    logic                unused_wdata_s;

    assign ctrl_we_s      = i_wr && (i_addr == ADDR_CTRL);
    assign tick_s         = en_q && (presc_cnt_q == '0);
    assign wrap_s         = tick_s && (period_q == '1);
    assign unused_wdata_s = ^i_wdata;

    assign o_rdata = rdata_q;
    assign o_ack   = ack_q;
    assign o_led   = led_q;

    // Channel configuration write decode.
    always_comb begin
        cfg_we_s = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (i_wr && (i_addr == ch_addr(n))) begin
                cfg_we_s[n] = 1'b1;
            end else begin
                cfg_we_s[n] = 1'b0;
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        led_pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_en       (en_q),
            .i_wrap     (wrap_s),
            .i_cfg_we   (cfg_we_s[n]),
            .i_cfg_wdata(i_wdata[CNT_W+1:0]),
            .i_period   (period_q),
            .o_cfg      (ch_cfg_s[n]),
            .o_led_next (led_next_s[n])
        );
    end

    // Read data multiplexer; unmapped words and unused bits read as zero.
    always_comb begin
        rd_mux_s = '0;
        case (i_addr)
            ADDR_CTRL: begin
                rd_mux_s[CTRL_EN_BIT]                  = en_q;
                rd_mux_s[CTRL_PRESC_LSB +: PRESC_W]    = presc_q;
            end
            ADDR_STATUS: begin
                rd_mux_s[CHANNELS-1:0] = led_q;
            end
            default: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    rd_mux_s[CNT_W+1:0] = (i_addr == ch_addr(n)) ? ch_cfg_s[n] : rd_mux_s[CNT_W+1:0];
                end
            end
        endcase
    end

    // Next state of control, timing and bus-response registers.
    always_comb begin
        en_d    = en_q;
        presc_d = presc_q;
        if (ctrl_we_s) begin
            en_d    = i_wdata[CTRL_EN_BIT];
            presc_d = i_wdata[CTRL_PRESC_LSB +: PRESC_W];
        end else begin
            en_d    = en_q;
            presc_d = presc_q;
        end

        // Enabling loads the prescaler so the first tick lands PRESC cycles later.
        if (!en_d) begin
            presc_cnt_d = '0;
        end else if (!en_q || tick_s) begin
            presc_cnt_d = presc_d;
        end else begin
            presc_cnt_d = presc_cnt_q - PRESC_ONE;
        end

        if (!en_d) begin
            period_d = '0;
        end else if (tick_s) begin
            period_d = period_q + CNT_ONE;
        end else begin
            period_d = period_q;
        end

        if (en_d) begin
            led_d = led_next_s;
        end else begin
            led_d = '0;
        end

        ack_d = i_wr || i_rd;
        // A combined read+write is treated as a write only.
        if (i_rd && !i_wr) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Top-level state registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            period_q    <= '0;
            led_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            en_q        <= en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            period_q    <= period_d;
            led_q       <= led_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed self-checking bench for led_pwm_ctrl with CHANNELS=4, CNT_W=4.
module tb_led_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack;
    logic [3:0]  led;

    int checks = 0;
    int errors = 0;

    led_pwm_ctrl #(
        .CHANNELS(4),
        .CNT_W   (4),
        .PRESC_W (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_wr   (wr),
        .i_rd   (rd),
        .i_addr (addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_ack  (ack),
        .o_led  (led)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = 4'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0; addr = 4'h0;
        d = rdata; k = ack;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic k;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", led); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        rst_n = 1'b1;
        bus_read(4'h0, d, k);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL reset_rd_ack: got %b expected 1", k); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_pwm();
        int k;
        logic e;
        bus_write(4'h0, 32'h1);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pwm_ctrl_ack: got %b expected 1", ack); end
        bus_write(4'h2, 32'h24);
        k = 0;
        while (led[0] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != 15) begin errors++; $display("FAIL pwm_first_rise: got %0d cycles expected 15", k); end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            e = (i < 4);
            checks++; if (led[0] !== e) begin errors++; $display("FAIL pwm_win[%0d]: got %b expected %b", i, led[0], e); end
        end
        // Duty 4 -> 12 written mid-period: current period stays 4-high.
        bus_write(4'h2, 32'h2C);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            e = (i < 2) || (i >= 14 && i < 26);
            checks++; if (led[0] !== e) begin errors++; $display("FAIL duty_chg[%0d]: got %b expected %b", i, led[0], e); end
        end
    endtask

    task automatic test_blink();
        int k;
        bus_write(4'h3, 32'h30);
        k = 0;
        while (led[1] !== 1'b1 && k < 80) begin @(negedge clk); k++; end
        checks++; if (k != 31) begin errors++; $display("FAIL blink_first: got %0d cycles expected 31", k); end
        k = 0;
        while (led[1] !== 1'b0 && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != 16) begin errors++; $display("FAIL blink_high_len: got %0d expected 16", k); end
        k = 0;
        while (led[1] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != 16) begin errors++; $display("FAIL blink_low_len: got %0d expected 16", k); end
        bus_write(4'h0, 32'h0);
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL disable_led: got %h expected 0", led); end
    endtask

    task automatic test_status_rw();
        logic [31:0] d;
        logic k;
        bus_write(4'h2, 32'h0);
        bus_write(4'h3, 32'h0);
        bus_write(4'h4, 32'h10);
        bus_write(4'h0, 32'h1);
        bus_read(4'h1, d, k);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL status_ack: got %b expected 1", k); end
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL status_val: got %h expected 4", d); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b expected 0", ack); end
        wr = 1'b1; rd = 1'b1; addr = 4'h3; wdata = 32'h05;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; addr = 4'h0; wdata = 32'h0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rdwr_ack: got %b expected 1", ack); end
        checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL rdwr_rdata: got %h expected 4", rdata); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rdwr_single_ack: got %b expected 0", ack); end
        bus_read(4'h3, d, k);
        checks++; if (d !== 32'h05) begin errors++; $display("FAIL rdwr_written: got %h expected 5", d); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] d;
        logic k;
        logic [31:0] exp_v [6];
        exp_v[0] = 32'h1; exp_v[1] = 32'h4; exp_v[2] = 32'h0;
        exp_v[3] = 32'h05; exp_v[4] = 32'h10; exp_v[5] = 32'h0;
        bus_read(4'hF, d, k);
        checks++; if (k !== 1'b1) begin errors++; $display("FAIL badrd_ack: got %b expected 1", k); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL badrd_data: got %h expected 0", d); end
        bus_write(4'h7, 32'hFFFF_FFFF);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL badwr_ack: got %b expected 1", ack); end
        bus_write(4'h1, 32'hFFFF_FFFF);
        for (int a = 0; a < 6; a++) begin
            bus_read(4'(a), d, k);
            checks++; if (d !== exp_v[a]) begin errors++; $display("FAIL map_after_bad[%0d]: got %h expected %h", a, d, exp_v[a]); end
        end
    endtask

    task automatic test_prescaler();
        int k;
        logic [31:0] d;
        logic ak;
        bus_write(4'h0, 32'h0);
        bus_write(4'h2, 32'h28);
        bus_write(4'h0, 32'h0001_0001);
        k = 0;
        while (led[0] === 1'b1 && k < 60) begin @(negedge clk); k++; end
        checks++; if (k != 17) begin errors++; $display("FAIL presc_first_high: got %0d expected 17", k); end
        k = 0;
        while (led[0] === 1'b0 && k < 60) begin @(negedge clk); k++; end
        checks++; if (k != 16) begin errors++; $display("FAIL presc_low: got %0d expected 16", k); end
        k = 0;
        while (led[0] === 1'b1 && k < 60) begin @(negedge clk); k++; end
        checks++; if (k != 16) begin errors++; $display("FAIL presc_high: got %0d expected 16", k); end
        bus_read(4'h0, d, ak);
        checks++; if (d !== 32'h0001_0001) begin errors++; $display("FAIL ctrl_readback: got %h expected 00010001", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic k;
        @(negedge clk);
        rd = 1'b1; addr = 4'h1;
        @(posedge clk);
        #2;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pre_rst_ack: got %b expected 1", ack); end
        checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL pre_rst_led: got %b expected 1", led[2]); end
        rst_n = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", ack); end
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL rst_led: got %h expected 0", led); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        rd = 1'b0; addr = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 6; a++) begin
            bus_read(4'(a), d, k);
            checks++; if (k !== 1'b1) begin errors++; $display("FAIL post_rst_ack[%0d]: got %b expected 1", a, k); end
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_rst_reg[%0d]: got %h expected 0", a, d); end
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_blink();
        test_status_rw();
        test_bad_addr();
        test_prescaler();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
